mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one 16-bit word-addressed memory bus between core instruction fetch (32-bit opcode, two beats)
//  and the core data port (LSU and RMW traffic).
//  Sits between core and memory: drives i_mem_opcode/i_mem_rdy and d_mem_rdy/d_mem_data_in.
//  Data has priority; a streak counter guarantees fetch progress. Fetch beats are never interleaved with data.
// PARAMETERS
//  DATA_STREAK_MAX  4  consecutive data grants allowed while a fetch is pending (1..15)
// PORTS
//  clk            in   1   clock, all logic on rising edge
//  a_rst          in   1   reset, synchronous, active-high
//  i_req          in   1   fetch request; held with i_pc stable until i_rdy
//  i_pc           in   16  fetch word address
//  i_flush        in   1   PC redirect; kills the pending/in-flight fetch response
//  i_rdy          out  1   one-cycle pulse: i_opcode valid
//  i_opcode       out  32  {word[i_pc+1], word[i_pc]}
//  d_assert       in   1   data request; held with addr/data/cmd/be stable until d_rdy
//  d_addr         in   16  data word address
//  d_wdata        in   16  write data
//  d_cmd          in   1   1=write, 0=read
//  d_be           in   2   byte enables {be1,be0}
//  d_rdy          out  1   one-cycle pulse: transfer done, d_rdata valid for reads
//  d_rdata        out  16  read data (registered)
//  bus_req        out  1   bus cycle request; held with addr/we/be/wdata stable until bus_ack
//  bus_addr       out  16  bus address
//  bus_we         out  1   bus write strobe
//  bus_be         out  2   bus byte enables
//  bus_wdata      out  16  bus write data
//  bus_rdata      in   16  bus read data, valid in bus_ack cycle
//  bus_ack        in   1   one-cycle completion pulse
// BEHAVIOUR
//  Reset values: i_rdy=0, d_rdy=0, bus_req=0, bus_we=0, bus_be=0, i_opcode=0, d_rdata=0, streak=0, state IDLE.
//  States:
//   IDLE: selects a grant; bus outputs registered, so bus_req rises the next cycle.
//   D_XFER: data beat.
//   I_LO: fetch word at i_pc.
//   I_HI: fetch word at i_pc+1 (16-bit wrap: 0xFFFF+1 = 0x0000).
//  IDLE grant: data if d_assert and (!i_req or streak<DATA_STREAK_MAX); else fetch if i_req; else stay.
//  Streak: +1 per data grant while i_req=1; cleared on fetch grant or when i_req=0; saturates.
//  D_XFER: on bus_ack -> latch bus_rdata into d_rdata (reads), d_rdy=1 next cycle, back to IDLE.
//   d_rdy is also pulsed for writes; d_rdata is unchanged on writes.
//  I_LO: on bus_ack -> latch low half, go to I_HI, re-issue bus_req with addr+1 the next cycle (no data in between).
//  I_HI: on bus_ack -> latch high half, i_rdy=1 next cycle unless killed, then IDLE.
//  Latency with zero-wait bus (ack in first req cycle): data 3 cycles d_assert->d_rdy; fetch 5 cycles i_req->i_rdy.
//  i_flush: sets a kill flag for the in-flight fetch. Beats complete on the bus (no abort), but i_rdy is suppressed.
//   In IDLE, an i_flush in the same cycle as a fetch grant kills that grant's response.
//   Kill clears on return to IDLE.
//  Simultaneous d_assert and i_req: data wins unless streak==DATA_STREAK_MAX.
//  Rdy pulse rule: i_rdy and d_rdy are never both 1. Requests are not re-sampled in the rdy cycle; IDLE resumes the next cycle.
//  Reset mid-transfer: bus_req drops at that edge, the transaction is abandoned and no rdy pulse is produced.
//   The bus slave tolerates a dropped request.
// CONFIGURATION
//  FETCH_BUFFER_EN defined:
//   One-entry buffer {valid, pc, opcode} written on every non-killed fetch completion.
//   IDLE with i_req and i_pc==buf.pc and valid: i_rdy next cycle, no bus cycle, streak cleared.
//   Invalidation: any data write whose address equals buf.pc or buf.pc+1, i_flush, and reset.
//  FETCH_BUFFER_EN undefined: every fetch uses the bus; buffer logic absent.
// STRUCTURE
//  Package mem_arb_pkg:
//   state encoding ST_IDLE/ST_D_XFER/ST_I_LO/ST_I_HI;
//   BEAT_LO/BEAT_HI;
//   STREAK_W=4.
//  Sub-module arb_streak_counter: saturating counter with clear and a limit compare,
//   instantiated once. Everything else is inline FSM plus output registers.
// TESTING
//  1 Read: d_assert rd 0x0040, slave returns 0xBEEF with ack in first req cycle
//    -> d_rdy at cycle 3, d_rdata=0xBEEF.
//  2 Fetch: i_pc=0x1000, mem[0x1000]=0x1234, mem[0x1001]=0xABCD
//    -> bus addrs 0x1000 then 0x1001, i_opcode=0xABCD1234.
//  3 Fairness: d_assert held continuously with i_req pending, DATA_STREAK_MAX=4
//    -> exactly 4 data grants, then the fetch, then data resumes.
//  4 Wrap: i_pc=0xFFFF -> second beat addr 0x0000.
//  5 Flush: i_flush during I_HI -> both bus beats complete, no i_rdy;
//    a new fetch of i_pc=0x2000 afterwards returns correct data.
//  6 Reset asserted during a pending D_XFER -> bus_req=0 next cycle, no d_rdy,
//    a read issued after reset completes normally.
//    With FETCH_BUFFER_EN: a repeated i_pc gives i_rdy 2 cycles after request and no bus_req;
//    a write to buf.pc+1 invalidates the buffer.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_D_XFER = 2'd1,
        ST_I_LO   = 2'd2,
        ST_I_HI   = 2'd3
    } arbState_e;

    typedef enum logic {
        BEAT_LO = 1'b0,
        BEAT_HI = 1'b1
    } beat_e;

    // Word address of a fetch beat; the high beat wraps at 16 bits.
    function automatic logic [15:0] beatAddr(input logic [15:0] pc, input beat_e beat);
        return pc + {15'd0, logic'(beat)};
    endfunction

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating count of consecutive data grants made while a fetch waits.
module arb_streak_counter
    import mem_arb_pkg::*;
#(
    parameter logic [STREAK_W-1:0] LIMIT = 4'd4
) (
    input  logic clk,
    input  logic a_rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic atLimit_o
);

    logic [STREAK_W-1:0] count_q;
    logic [STREAK_W-1:0] count_d;

    // Clear wins over increment; the count stops at the limit.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q < LIMIT)) begin
            count_d = count_q + STREAK_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (a_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign atLimit_o = (count_q >= LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 16-bit word bus between two-beat instruction fetch and the data port.
// Data has priority, bounded by a streak counter so fetch always progresses.
// Optional feature: define FETCH_BUFFER_EN for a one-entry fetch result buffer.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_STREAK_MAX = 4
) (
    input  logic        clk,
    input  logic        a_rst,
    input  logic        i_req,
    input  logic [15:0] i_pc,
    input  logic        i_flush,
    output logic        i_rdy,
    output logic [31:0] i_opcode,
    input  logic        d_assert,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    input  logic        d_cmd,
    input  logic [1:0]  d_be,
    output logic        d_rdy,
    output logic [15:0] d_rdata,
    output logic        bus_req,
    output logic [15:0] bus_addr,
    output logic        bus_we,
    output logic [1:0]  bus_be,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata,
    input  logic        bus_ack
);

    arbState_e   state_q, state_d;
    logic        busReq_q, busReq_d;
    logic [15:0] busAddr_q, busAddr_d;
    logic        busWe_q, busWe_d;
    logic [1:0]  busBe_q, busBe_d;
    logic [15:0] busWdata_q, busWdata_d;
    logic        iRdy_q, iRdy_d;
    logic        dRdy_q, dRdy_d;
    logic [31:0] iOpcode_q, iOpcode_d;
    logic [15:0] dRdata_q, dRdata_d;
    logic [15:0] loHalf_q, loHalf_d;
    logic [15:0] fetchPc_q, fetchPc_d;
    logic        kill_q, kill_d;

    logic idleFree, busDone, grantData, fetchSel, grantFetch, bufHit;
    logic streakAtLimit, streakClr, streakInc, fetchKilled;

    // The rdy cycle is not a grant cycle: requesters still hold their request then.
    assign idleFree    = (state_q == ST_IDLE) && !iRdy_q && !dRdy_q;
    assign busDone     = busReq_q && bus_ack;
    assign grantData   = idleFree && d_assert && (!i_req || !streakAtLimit);
    assign fetchSel    = idleFree && !grantData && i_req;
    assign fetchKilled = kill_q || i_flush;

`ifdef FETCH_BUFFER_EN
    logic        bufValid_q, bufValid_d;
    logic [15:0] bufPc_q, bufPc_d;
    logic [31:0] bufOpcode_q, bufOpcode_d;

    assign bufHit = fetchSel && bufValid_q && (i_pc == bufPc_q) && !i_flush;
`else
    assign bufHit = 1'b0;
`endif

    assign grantFetch = fetchSel && !bufHit;
    assign streakInc  = grantData && i_req;
    assign streakClr  = !i_req || grantFetch || bufHit;

    arb_streak_counter #(
        .LIMIT(STREAK_W'(DATA_STREAK_MAX))
    ) u_streak (
        .clk      (clk),
        .a_rst    (a_rst),
        .clr_i    (streakClr),
        .inc_i    (streakInc),
        .atLimit_o(streakAtLimit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (a_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one grant per IDLE visit, each beat advances on its ack.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (grantData) state_d = ST_D_XFER;
                       else if (grantFetch) state_d = ST_I_LO;
            ST_D_XFER: if (busDone) state_d = ST_IDLE;
            ST_I_LO:   if (busDone) state_d = ST_I_HI;
            ST_I_HI:   if (busDone) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output next values: bus cycle setup, beat capture, rdy pulses and fetch kill.
    always_comb begin
        busReq_d   = busReq_q;
        busAddr_d  = busAddr_q;
        busWe_d    = busWe_q;
        busBe_d    = busBe_q;
        busWdata_d = busWdata_q;
        iRdy_d     = 1'b0;
        dRdy_d     = 1'b0;
        iOpcode_d  = iOpcode_q;
        dRdata_d   = dRdata_q;
        loHalf_d   = loHalf_q;
        fetchPc_d  = fetchPc_q;
        kill_d     = kill_q;
        unique case (state_q)
            ST_IDLE: begin
                kill_d = 1'b0;
                if (grantData) begin
                    busReq_d   = 1'b1;
                    busAddr_d  = d_addr;
                    busWe_d    = d_cmd;
                    busBe_d    = d_be;
                    busWdata_d = d_wdata;
                end else if (grantFetch) begin
                    busReq_d  = 1'b1;
                    busAddr_d = beatAddr(i_pc, BEAT_LO);
                    busWe_d   = 1'b0;
                    busBe_d   = 2'b11;
                    fetchPc_d = i_pc;
                    kill_d    = i_flush;
                end
`ifdef FETCH_BUFFER_EN
                else if (bufHit) begin
                    iRdy_d    = 1'b1;
                    iOpcode_d = bufOpcode_q;
                end
`endif
            end
            ST_D_XFER: begin
                if (busDone) begin
                    busReq_d = 1'b0;
                    busWe_d  = 1'b0;
                    busBe_d  = 2'b00;
                    dRdy_d   = 1'b1;
                    if (!busWe_q) dRdata_d = bus_rdata;
                end
            end
            ST_I_LO: begin
                if (i_flush) kill_d = 1'b1;
                if (busDone) begin
                    busReq_d  = 1'b0;
                    busAddr_d = beatAddr(fetchPc_q, BEAT_HI);
                    loHalf_d  = bus_rdata;
                end
            end
            ST_I_HI: begin
                if (i_flush) kill_d = 1'b1;
                if (!busReq_q) begin
                    busReq_d = 1'b1;
                end else if (busDone) begin
                    busReq_d = 1'b0;
                    busBe_d  = 2'b00;
                    kill_d   = 1'b0;
                    iRdy_d   = !fetchKilled;
                    if (!fetchKilled) iOpcode_d = {bus_rdata, loHalf_q};
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers; reset drops any bus cycle in progress.
    always_ff @(posedge clk) begin
        if (a_rst) begin
            busReq_q   <= 1'b0;
            busAddr_q  <= '0;
            busWe_q    <= 1'b0;
            busBe_q    <= '0;
            busWdata_q <= '0;
            iRdy_q     <= 1'b0;
            dRdy_q     <= 1'b0;
            iOpcode_q  <= '0;
            dRdata_q   <= '0;
            loHalf_q   <= '0;
            fetchPc_q  <= '0;
            kill_q     <= 1'b0;
        end else begin
            busReq_q   <= busReq_d;
            busAddr_q  <= busAddr_d;
            busWe_q    <= busWe_d;
            busBe_q    <= busBe_d;
            busWdata_q <= busWdata_d;
            iRdy_q     <= iRdy_d;
            dRdy_q     <= dRdy_d;
            iOpcode_q  <= iOpcode_d;
            dRdata_q   <= dRdata_d;
            loHalf_q   <= loHalf_d;
            fetchPc_q  <= fetchPc_d;
            kill_q     <= kill_d;
        end
    end

`ifdef FETCH_BUFFER_EN
    // Buffer fill on delivered fetches; flushes and writes overlapping the entry invalidate it.
    always_comb begin
        bufValid_d  = bufValid_q;
        bufPc_d     = bufPc_q;
        bufOpcode_d = bufOpcode_q;
        if ((state_q == ST_I_HI) && busDone && !fetchKilled) begin
            bufValid_d  = 1'b1;
            bufPc_d     = fetchPc_q;
            bufOpcode_d = {bus_rdata, loHalf_q};
        end
        if (i_flush) begin
            bufValid_d = 1'b0;
        end
        if (grantData && d_cmd && ((d_addr == bufPc_q) || (d_addr == bufPc_q + 16'd1))) begin
            bufValid_d = 1'b0;
        end
    end

    // Fetch buffer registers.
    always_ff @(posedge clk) begin
        if (a_rst) begin
            bufValid_q  <= 1'b0;
            bufPc_q     <= '0;
            bufOpcode_q <= '0;
        end else begin
            bufValid_q  <= bufValid_d;
            bufPc_q     <= bufPc_d;
            bufOpcode_q <= bufOpcode_d;
        end
    end
`endif

    assign bus_req   = busReq_q;
    assign bus_addr  = busAddr_q;
    assign bus_we    = busWe_q;
    assign bus_be    = busBe_q;
    assign bus_wdata = busWdata_q;
    assign i_rdy     = iRdy_q;
    assign d_rdy     = dRdy_q;
    assign i_opcode  = iOpcode_q;
    assign d_rdata   = dRdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus hand-written corner sequences,
// a memory slave model with configurable wait states, and a scoreboard of expected rdy results.
// Optional feature covered when FETCH_BUFFER_EN is defined.
module tb_mem_port_arbiter;

    typedef struct {
        logic        isFetch;
        logic        isWrite;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        int          waits;
        logic [31:0] expData;
    } vec_t;

    typedef struct {
        logic        isFetch;
        logic [31:0] data;
    } sbEntry_t;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [1:0]  be;
    } busTxn_t;

    logic        clk;
    logic        a_rst;
    logic        i_req;
    logic [15:0] i_pc;
    logic        i_flush;
    logic        i_rdy;
    logic [31:0] i_opcode;
    logic        d_assert;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_cmd;
    logic [1:0]  d_be;
    logic        d_rdy;
    logic [15:0] d_rdata;
    logic        bus_req;
    logic [15:0] bus_addr;
    logic        bus_we;
    logic [1:0]  bus_be;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_ack;

    int checks = 0;
    int failures = 0;
    int waitStates = 0;
    int waitCnt = 0;
    int iRdyCount = 0;
    int dRdyCount = 0;
    logic [15:0] lastRead = 16'h0000;
    logic [15:0] mem [0:65535];
    sbEntry_t expQ[$];
    busTxn_t busLog[$];
    vec_t vecs[10];

    mem_port_arbiter #(.DATA_STREAK_MAX(4)) dut (
        .clk      (clk),
        .a_rst    (a_rst),
        .i_req    (i_req),
        .i_pc     (i_pc),
        .i_flush  (i_flush),
        .i_rdy    (i_rdy),
        .i_opcode (i_opcode),
        .d_assert (d_assert),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_cmd    (d_cmd),
        .d_be     (d_be),
        .d_rdy    (d_rdy),
        .d_rdata  (d_rdata),
        .bus_req  (bus_req),
        .bus_addr (bus_addr),
        .bus_we   (bus_we),
        .bus_be   (bus_be),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ack  (bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Memory slave: acks after waitStates idle request cycles, performs byte-enabled writes.
    always @(negedge clk) begin
        if (bus_req) begin
            if (waitCnt >= waitStates) begin
                bus_ack = 1'b1;
                bus_rdata = mem[bus_addr];
                if (bus_we) begin
                    if (bus_be[0]) mem[bus_addr][7:0] = bus_wdata[7:0];
                    if (bus_be[1]) mem[bus_addr][15:8] = bus_wdata[15:8];
                end
                busLog.push_back('{addr: bus_addr, we: bus_we, be: bus_be});
                waitCnt = 0;
            end else begin
                bus_ack = 1'b0;
                waitCnt++;
            end
        end else begin
            bus_ack = 1'b0;
            waitCnt = 0;
        end
    end

    // Scoreboard: every rdy pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        sbEntry_t e;
        if (i_rdy || d_rdy) begin
            if (i_rdy) iRdyCount++;
            if (d_rdy) dRdyCount++;
            checkOutput("rdy_exclusive", 32'(i_rdy & d_rdy), 32'd0);
            if (expQ.size() == 0) begin
                checkOutput("unexpected_rdy", {30'd0, i_rdy, d_rdy}, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("rdy_kind", 32'(i_rdy), 32'(e.isFetch));
                checkOutput("rdy_data", e.isFetch ? i_opcode : {16'd0, d_rdata}, e.data);
            end
        end
    end

    task automatic applyStimulus(input vec_t v, input int expLat, input int expBeats);
        int lat;
        int base;
        sbEntry_t e;
        lat = 0;
        waitStates = v.waits;
        @(posedge clk);
        #1;
        base = busLog.size();
        e.isFetch = v.isFetch;
        if (v.isFetch) begin
            i_pc = v.addr;
            i_req = 1'b1;
            e.data = v.expData;
        end else begin
            d_addr = v.addr;
            d_wdata = v.wdata;
            d_cmd = v.isWrite;
            d_be = v.be;
            d_assert = 1'b1;
            if (v.isWrite) begin
                e.data = {16'd0, lastRead};
            end else begin
                e.data = v.expData;
                lastRead = v.expData[15:0];
            end
        end
        expQ.push_back(e);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if ((v.isFetch && i_rdy) || (!v.isFetch && d_rdy)) begin
                lat = c;
                break;
            end
        end
        i_req = 1'b0;
        d_assert = 1'b0;
        checkOutput("latency", 32'(lat), 32'(expLat));
        checkOutput("bus_beats", 32'(busLog.size() - base), 32'(expBeats));
        if (busLog.size() - base >= 1) begin
            checkOutput("beat0_addr", {16'd0, busLog[base].addr}, {16'd0, v.addr});
            if (!v.isFetch) begin
                checkOutput("beat0_we", 32'(busLog[base].we), 32'(v.isWrite));
                checkOutput("beat0_be", 32'(busLog[base].be), 32'(v.be));
            end
        end
        if (busLog.size() - base >= 2) begin
            checkOutput("beat1_addr", {16'd0, busLog[base + 1].addr}, {16'd0, 16'(v.addr + 16'd1)});
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        int iBase;
        int dBase;
        int found;
        int dCnt;
        int fetchPos;
        int seqLog[$];
        vec_t v;

        for (int a = 0; a < 65536; a++) mem[a] = 16'(a) ^ 16'h5A5A;
        mem[16'h0040] = 16'hBEEF;
        mem[16'h1000] = 16'h1234;
        mem[16'h1001] = 16'hABCD;
        mem[16'hFFFF] = 16'h7777;
        mem[16'h0000] = 16'h8888;
        mem[16'h1234] = 16'hC0DE;
        mem[16'h1235] = 16'hF00D;
        mem[16'h2000] = 16'h1111;
        mem[16'h2001] = 16'h2222;
        mem[16'h4000] = 16'h4444;
        mem[16'h4001] = 16'h5555;

        //              fetch  write addr      wdata     be     waits exp
        vecs[0] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 2'b11, 0, 32'h0000_BEEF};
        vecs[1] = '{1'b1, 1'b0, 16'h1000, 16'h0000, 2'b11, 0, 32'hABCD_1234};
        vecs[2] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 2'b11, 0, 32'h8888_7777};
        vecs[3] = '{1'b0, 1'b1, 16'h0100, 16'h1122, 2'b11, 0, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 16'h0100, 16'h0000, 2'b11, 0, 32'h0000_1122};
        vecs[5] = '{1'b0, 1'b1, 16'h0100, 16'h33FF, 2'b01, 0, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 16'h0100, 16'h0000, 2'b11, 2, 32'h0000_11FF};
        vecs[7] = '{1'b0, 1'b1, 16'h0100, 16'hAA00, 2'b10, 1, 32'h0};
        vecs[8] = '{1'b0, 1'b0, 16'h0100, 16'h0000, 2'b11, 0, 32'h0000_AAFF};
        vecs[9] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 2'b11, 1, 32'hF00D_C0DE};

        a_rst = 1'b1;
        i_req = 1'b0;
        i_pc = 16'h0;
        i_flush = 1'b0;
        d_assert = 1'b0;
        d_addr = 16'h0;
        d_wdata = 16'h0;
        d_cmd = 1'b0;
        d_be = 2'b00;
        bus_ack = 1'b0;
        bus_rdata = 16'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_i_rdy", 32'(i_rdy), 32'd0);
        checkOutput("rst_d_rdy", 32'(d_rdy), 32'd0);
        checkOutput("rst_bus_req", 32'(bus_req), 32'd0);
        checkOutput("rst_bus_we", 32'(bus_we), 32'd0);
        checkOutput("rst_bus_be", 32'(bus_be), 32'd0);
        checkOutput("rst_i_opcode", i_opcode, 32'd0);
        checkOutput("rst_d_rdata", {16'd0, d_rdata}, 32'd0);
        a_rst = 1'b0;

        for (int k = 0; k < 10; k++) begin
            v = vecs[k];
            if (v.isFetch) applyStimulus(v, 5 + 2 * v.waits, 2);
            else applyStimulus(v, 3 + v.waits, 1);
        end

        // Data held continuously against a pending fetch: four data grants, then the fetch.
        waitStates = 0;
        @(posedge clk);
        #1;
        i_pc = 16'h1000;
        i_req = 1'b1;
        d_addr = 16'h0040;
        d_cmd = 1'b0;
        d_be = 2'b11;
        d_assert = 1'b1;
        for (int k = 0; k < 4; k++) expQ.push_back('{isFetch: 1'b0, data: 32'h0000_BEEF});
        expQ.push_back('{isFetch: 1'b1, data: 32'hABCD_1234});
        for (int k = 0; k < 2; k++) expQ.push_back('{isFetch: 1'b0, data: 32'h0000_BEEF});
        lastRead = 16'hBEEF;
        dCnt = 0;
        for (int c = 0; c < 300 && dCnt < 6; c++) begin
            @(negedge clk);
            if (d_rdy) begin
                seqLog.push_back(0);
                dCnt++;
                if (dCnt == 6) d_assert = 1'b0;
            end
            if (i_rdy) begin
                seqLog.push_back(1);
                i_req = 1'b0;
            end
        end
        d_assert = 1'b0;
        i_req = 1'b0;
        fetchPos = -1;
        foreach (seqLog[k]) if (seqLog[k] == 1 && fetchPos < 0) fetchPos = k;
        checkOutput("fair_data_count", 32'(dCnt), 32'd6);
        checkOutput("fair_fetch_pos", 32'(fetchPos), 32'd4);

        // Flush during the high beat: both beats still run, no i_rdy.
        @(posedge clk);
        #1;
        base = busLog.size();
        iBase = iRdyCount;
        i_pc = 16'h3000;
        i_req = 1'b1;
        found = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #2;
            if (busLog.size() == base + 1) begin
                found = 1;
                break;
            end
        end
        checkOutput("flush_lo_beat", 32'(found), 32'd1);
        i_flush = 1'b1;
        i_req = 1'b0;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busLog.size() == base + 2) break;
        end
        repeat (4) @(negedge clk);
        checkOutput("flush_beats", 32'(busLog.size() - base), 32'd2);
        if (busLog.size() - base >= 2) begin
            checkOutput("flush_lo_addr", {16'd0, busLog[base].addr}, 32'h3000);
            checkOutput("flush_hi_addr", {16'd0, busLog[base + 1].addr}, 32'h3001);
        end
        checkOutput("flush_no_irdy", 32'(iRdyCount - iBase), 32'd0);
        applyStimulus('{1'b1, 1'b0, 16'h2000, 16'h0, 2'b11, 0, 32'h2222_1111}, 5, 2);

        // Reset while a data beat waits on the slave: request dropped, no d_rdy.
        waitStates = 3;
        @(posedge clk);
        #1;
        dBase = dRdyCount;
        d_addr = 16'h0050;
        d_cmd = 1'b0;
        d_be = 2'b11;
        d_assert = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_pending_req", 32'(bus_req), 32'd1);
        a_rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_drop_req", 32'(bus_req), 32'd0);
        checkOutput("rst_no_drdy", 32'(d_rdy), 32'd0);
        a_rst = 1'b0;
        d_assert = 1'b0;
        lastRead = 16'h0000;
        repeat (5) @(negedge clk);
        checkOutput("rst_drdy_count", 32'(dRdyCount - dBase), 32'd0);
        checkOutput("rst_d_rdata_clr", {16'd0, d_rdata}, 32'd0);
        applyStimulus('{1'b0, 1'b0, 16'h0040, 16'h0, 2'b11, 0, 32'h0000_BEEF}, 3, 1);

`ifdef FETCH_BUFFER_EN
        // Repeated fetch served from the buffer; a write to pc+1 invalidates it.
        applyStimulus('{1'b1, 1'b0, 16'h4000, 16'h0, 2'b11, 0, 32'h5555_4444}, 5, 2);
        applyStimulus('{1'b1, 1'b0, 16'h4000, 16'h0, 2'b11, 0, 32'h5555_4444}, 2, 0);
        applyStimulus('{1'b0, 1'b1, 16'h4001, 16'h6666, 2'b11, 0, 32'h0}, 3, 1);
        applyStimulus('{1'b1, 1'b0, 16'h4000, 16'h0, 2'b11, 0, 32'h6666_4444}, 5, 2);
`endif

        repeat (3) @(negedge clk);
        checkOutput("sb_drained", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
